apb_master: RTL and testbench
=============================

// Module: apb_master
// PURPOSE
//  Upstream APB requester for APB_SLAVE. Accepts simple valid/ready read/write requests, buffers
//  them in a small FIFO and drives APB SETUP/ACCESS phases. Returns one response per request.
//  Sits between the arbiter's granted request stream and the slave's psel/penable port.
// PARAMETERS
//  ADDR_W          10   APB address width; matches APB_SLAVE paddr_i
//  DATA_W          32   APB data width
//  FIFO_DEPTH      2    request buffer entries; power of 2, >=2
//  TIMEOUT_CYCLES  32   ACCESS-phase watchdog limit; used only with APB_MASTER_TIMEOUT_EN
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  reset        in   1       asynchronous, active-high reset
//  req_valid_i  in   1       request present
//  req_ready_o  out  1       FIFO can accept a request (= FIFO not full)
//  req_write_i  in   1       1 = write, 0 = read
//  req_addr_i   in   ADDR_W  request address
//  req_wdata_i  in   DATA_W  write data (ignored for reads)
//  rsp_valid_o  out  1       one-cycle pulse: transfer completed
//  rsp_rdata_o  out  DATA_W  read data (0 for writes); valid only with rsp_valid_o
//  rsp_err_o    out  1       transfer timed out; valid only with rsp_valid_o
//  psel_o       out  1       APB select
//  penable_o    out  1       APB enable
//  paddr_o      out  ADDR_W  APB address
//  pwrite_o     out  1       APB direction
//  pwdata_o     out  DATA_W  APB write data
//  prdata_i     in   DATA_W  APB read data
//  pready_i     in   1       APB ready
// BEHAVIOUR
//  - Reset (async): FSM to IDLE, FIFO emptied, in-flight transfer dropped with no response.
//    All outputs 0, except req_ready_o=1 once reset is deasserted.
//  - Enqueue when req_valid_i & req_ready_o. A push and a pop in the same cycle are both legal
//    when full; req_ready_o is registered-state based (not-full only; no combinational pop bypass).
//  - FSM IDLE: psel_o=0, penable_o=0. If FIFO non-empty, pop the head into paddr/pwrite/pwdata regs
//    and go to SETUP. A request pushed into an empty FIFO reaches SETUP 2 cycles later (push, pop).
//  - SETUP: psel_o=1, penable_o=0. Always exactly one cycle, then ACCESS.
//  - ACCESS: psel_o=1, penable_o=1. Hold paddr/pwrite/pwdata stable until pready_i=1.
//    On pready_i: rsp_valid_o=1 next cycle. rsp_rdata_o = prdata_i sampled that edge for reads,
//    0 for writes; rsp_err_o=0. Then go to SETUP directly if FIFO is non-empty (back-to-back,
//    psel_o stays 1, penable_o drops for one cycle); otherwise go to IDLE.
//  - pready_i is ignored in IDLE and SETUP. The slave may raise it early; that must not complete
//    a transfer.
//  - paddr/pwrite/pwdata hold their last values in IDLE (no toggle needed).
//  - Ordering: responses are returned strictly in request order; there is never more than one
//    outstanding transfer.
//  - FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs match.
// CONFIGURATION
//  APB_MASTER_TIMEOUT_EN defined: an 8-bit-min counter clears on SETUP entry and increments each
//    ACCESS cycle. At TIMEOUT_CYCLES without pready_i: abort (psel_o/penable_o drop to 0), pulse
//    rsp_valid_o with rsp_err_o=1 and rsp_rdata_o=0, then continue with the FIFO as normal.
//    pready_i arriving in the same cycle as the limit wins (normal completion).
//  Not defined: ACCESS waits indefinitely; rsp_err_o tied 0; no counter logic present.
// STRUCTURE
//  Package apb_pkg: apb_state_e enum {IDLE, SETUP, ACCESS}; apb_req_t struct {write, addr, wdata};
//    localparams APB_ADDR_W=10, APB_DATA_W=32.
//  Sub-module apb_req_fifo: sync FIFO of apb_req_t (push/pop/full/empty), async reset.
//  FSM, output regs and watchdog live in apb_master.
// TESTING
//  1 Single write A=0x3, D=0xDEADBEEF, pready_i=1 on the 1st ACCESS cycle -> SETUP 1 cycle,
//    ACCESS 1 cycle, rsp_valid_o pulse, rsp_err_o=0.
//  2 Read A=0x3 with pready_i low for 5 ACCESS cycles, prdata_i=0xDEADBEEF -> paddr held,
//    penable_o=1 for 6 cycles, rsp_rdata_o=0xDEADBEEF.
//  3 Three back-to-back requests, pready always 1 -> req_ready_o=0 after 2 queued;
//    SETUP/ACCESS alternate with psel_o never dropping; 3 responses in order.
//  4 pready_i=1 held during IDLE and SETUP -> no early completion; each ACCESS lasts >=1 cycle.
//  5 Assert reset during ACCESS with 2 queued -> next cycle all outputs 0, no rsp_valid_o,
//    FIFO empty after release.
//  6 [APB_MASTER_TIMEOUT_EN] pready_i stuck 0 -> abort after 32 ACCESS cycles, rsp_err_o=1;
//    the queued next request then completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB requester: FSM state encoding and the buffered request record.
package apb_pkg;

    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/apb_master_if.sv
// Request/response stream plus APB bus of the requester; signal suffixes are from the master's view.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              psel_o;
    logic              penable_o;
    logic [ADDR_W-1:0] paddr_o;
    logic              pwrite_o;
    logic [DATA_W-1:0] pwdata_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
    );

endinterface

// File: rtl/apb_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full and empty are distinguishable.
module apb_req_fifo
    import apb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_push,
    input  apb_req_t i_data,
    input  logic     i_pop,
    output apb_req_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int AW = $clog2(DEPTH);

    apb_req_t      r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: buffers valid/ready requests and runs one SETUP/ACCESS transfer at a time.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W     = APB_ADDR_W,
    parameter int DATA_W     = APB_DATA_W,
    parameter int FIFO_DEPTH = 2
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 32
`endif
) (
    input logic         clk,
    input logic         reset,
    apb_master_if.master bus
);

    apb_state_e        r_state;
    logic              r_psel;
    logic              r_penable;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    apb_req_t w_push_req;
    apb_req_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_push;
    logic     w_pop;
    logic     w_done;
    logic     w_abort;

    assign w_push_req      = '{write: bus.req_write_i, addr: bus.req_addr_i, wdata: bus.req_wdata_i};
    assign bus.req_ready_o = ~w_full & ~reset;
    assign w_push          = bus.req_valid_i & bus.req_ready_o;
    assign w_done          = (r_state == ACCESS) & bus.pready_i;
    // A new transfer starts from IDLE or straight out of a completing ACCESS.
    assign w_pop           = ~w_empty & ((r_state == IDLE) | w_done);

    apb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_tmo_cnt;

    // The counter holds the number of ACCESS cycles already spent before the current one.
    assign w_abort = (r_state == ACCESS) & ~bus.pready_i & (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_tmo_cnt <= '0;
        else if (w_pop)             r_tmo_cnt <= '0;
        else if (r_state == ACCESS) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
`else
    assign w_abort = 1'b0;
`endif

    // NOTE: state and outputs use <= so every branch below sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            if (w_pop) begin
                r_paddr  <= w_head.addr;
                r_pwrite <= w_head.write;
                r_pwdata <= w_head.wdata;
            end
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= SETUP;
                        r_psel  <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (w_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_pwrite ? '0 : bus.prdata_i;
                        r_penable   <= 1'b0;
                        r_psel      <= ~w_empty;
                        r_state     <= w_empty ? IDLE : SETUP;
                    end else if (w_abort) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.psel_o      = r_psel;
    assign bus.penable_o   = r_penable;
    assign bus.paddr_o     = r_paddr;
    assign bus.pwrite_o    = r_pwrite;
    assign bus.pwdata_o    = r_pwdata;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a memory-backed APB slave model checks the bus, a monitor checks responses.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = APB_ADDR_W;
    localparam int DW = APB_DATA_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic write; logic [AW-1:0] addr; logic [DW-1:0] wdata; } xfer_t;
    typedef struct { logic err; logic [DW-1:0] rdata; } rsp_t;

    int n_checks = 0;
    int n_errors = 0;

    xfer_t         apb_q [$];
    rsp_t          rsp_q [$];
    logic [DW-1:0] model_mem [1<<AW];
    logic [DW-1:0] slave_mem [1<<AW];

    // Slave-model controls and observations.
    int fixed_wait = -1;
    int max_wait   = 3;
    bit early_mode = 0;
    bit hang       = 0;
    bit stuck      = 0;
    int wait_left, acc_run, psel_run, last_acc_run, last_psel_run;
    bit hold_prev, in_xfer, rsp_due;
    logic  s_acc;
    xfer_t held, s_exp;
    rsp_t  m_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no event expected one", name);
    endtask

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hA500_0000 ^ (a * 32'h0001_0003);
    endfunction

    // Caller is at a negedge; returns at the negedge after the request was accepted.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit aborted);
        int guard = 0;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = w;
        bus.req_addr_i  = a;
        bus.req_wdata_i = d;
        while (!bus.req_ready_o && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready_o) begin
            fail("req_ready_timeout");
            bus.req_valid_i = 1'b0;
            return;
        end
        if (aborted) begin
            rsp_q.push_back('{1'b1, 32'h0});
        end else begin
            apb_q.push_back('{w, a, d});
            if (w) begin
                model_mem[a] = d;
                rsp_q.push_back('{1'b0, 32'h0});
            end else begin
                rsp_q.push_back('{1'b0, model_mem[a]});
            end
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((apb_q.size() != 0 || rsp_q.size() != 0 || bus.psel_o) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) fail("drain_timeout");
        @(negedge clk);
    endtask

    // APB slave model: memory-backed, random wait states, random early pready outside ACCESS.
    always @(negedge clk) begin : apb_slave
        if (reset) begin
            bus.pready_i = 1'b0;
            hold_prev    = 0;
            in_xfer      = 0;
            acc_run      = 0;
            psel_run     = 0;
            rsp_due      = 0;
        end else begin
            s_acc = bus.psel_o & bus.penable_o;
            if (!s_acc && acc_run > 0) begin
                last_acc_run = acc_run;
                acc_run      = 0;
                stuck        = 0;
                rsp_due      = 1;
            end
            check("rsp_timing", bus.rsp_valid_o, rsp_due);
            rsp_due = 0;
            if (bus.penable_o) check("penable_has_psel", bus.psel_o, 1'b1);
            if (hold_prev) begin
                check("access_follows", s_acc, 1'b1);
                check("paddr_held", bus.paddr_o, held.addr);
                check("pwrite_held", bus.pwrite_o, held.write);
                check("pwdata_held", bus.pwdata_o, held.wdata);
            end
            if (bus.psel_o) psel_run++;
            else begin
                if (psel_run > 0) last_psel_run = psel_run;
                psel_run = 0;
            end
            if (s_acc) begin
                check("access_legal", in_xfer, 1'b1);
                acc_run++;
                held = '{bus.pwrite_o, bus.paddr_o, bus.pwdata_o};
                if (stuck || hang) begin
                    bus.pready_i = 1'b0;
                    hold_prev    = hang;
                    in_xfer      = 1;
                end else if (wait_left > 0) begin
                    bus.pready_i = 1'b0;
                    wait_left--;
                    hold_prev = 1;
                    in_xfer   = 1;
                end else begin
                    bus.pready_i = 1'b1;
                    hold_prev    = 0;
                    in_xfer      = 0;
                    rsp_due      = 1;
                    last_acc_run = acc_run;
                    acc_run      = 0;
                    if (apb_q.size() == 0) fail("xfer_unexpected");
                    else begin
                        s_exp = apb_q.pop_front();
                        check("xfer_write", bus.pwrite_o, s_exp.write);
                        check("xfer_addr", bus.paddr_o, s_exp.addr);
                        if (s_exp.write) check("xfer_wdata", bus.pwdata_o, s_exp.wdata);
                    end
                    if (bus.pwrite_o) begin
                        slave_mem[bus.paddr_o] = bus.pwdata_o;
                        bus.prdata_i = $urandom;
                    end else begin
                        bus.prdata_i = slave_mem[bus.paddr_o];
                    end
                end
            end else begin
                bus.pready_i = early_mode ? 1'b1 : 1'($urandom_range(0, 1));
                bus.prdata_i = $urandom;
                hold_prev    = bus.psel_o;
                in_xfer      = bus.psel_o;
                if (bus.psel_o) begin
                    held      = '{bus.pwrite_o, bus.paddr_o, bus.pwdata_o};
                    wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, max_wait));
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin : rsp_monitor
        if (!reset && bus.rsp_valid_o) begin
            if (rsp_q.size() == 0) fail("rsp_unexpected");
            else begin
                m_exp = rsp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata_o, m_exp.rdata);
                check("rsp_err", bus.rsp_err_o, m_exp.err);
            end
        end
    end

    initial begin : watchdog
        #500000;
        fail("global_timeout");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : main
        for (int a = 0; a < (1 << AW); a++) begin
            model_mem[a] = init_word(a);
            slave_mem[a] = init_word(a);
        end
        reset           = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.pready_i    = 1'b0;
        bus.prdata_i    = '0;
        repeat (3) @(negedge clk);
        check("rst_psel", bus.psel_o, 1'b0);
        check("rst_penable", bus.penable_o, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid_o, 1'b0);
        check("rst_ready", bus.req_ready_o, 1'b0);
        check("rst_paddr", bus.paddr_o, '0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.req_ready_o, 1'b1);

        // Single write, zero wait: IDLE one cycle, SETUP, one ACCESS.
        fixed_wait = 0;
        send(1'b1, 10'h3, 32'hDEAD_BEEF, 1'b0);
        check("lat_idle_psel", bus.psel_o, 1'b0);
        @(negedge clk);
        check("lat_setup_psel", bus.psel_o, 1'b1);
        check("lat_setup_penable", bus.penable_o, 1'b0);
        @(negedge clk);
        check("lat_access_penable", bus.penable_o, 1'b1);
        wait_idle();
        check("write_access_len", last_acc_run, 1);

        // Read with five wait states.
        fixed_wait = 5;
        send(1'b0, 10'h3, 32'h0, 1'b0);
        wait_idle();
        check("read_access_len", last_acc_run, 6);

        // Three back-to-back requests fill the FIFO and keep psel high.
        fixed_wait = 0;
        send(1'b1, 10'h10, 32'h1111_0001, 1'b0);
        send(1'b0, 10'h10, 32'h0, 1'b0);
        send(1'b0, 10'h3, 32'h0, 1'b0);
        check("full_ready", bus.req_ready_o, 1'b0);
        wait_idle();
        check("b2b_psel_run", last_psel_run, 6);

        // pready held high outside ACCESS must not finish a transfer early.
        early_mode = 1;
        send(1'b1, 10'h21, 32'hCAFE_0021, 1'b0);
        wait_idle();
        check("early_ready_len", last_acc_run, 1);
        send(1'b0, 10'h21, 32'h0, 1'b0);
        wait_idle();
        check("early_ready_len2", last_acc_run, 1);
        early_mode = 0;

        // Reset during ACCESS with the FIFO full: everything dropped, no response.
        hang = 1;
        send(1'b0, 10'h5, 32'h0, 1'b0);
        send(1'b0, 10'h6, 32'h0, 1'b0);
        send(1'b0, 10'h7, 32'h0, 1'b0);
        @(negedge clk);
        check("hang_in_access", bus.penable_o, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_psel", bus.psel_o, 1'b0);
        check("arst_penable", bus.penable_o, 1'b0);
        check("arst_rsp_valid", bus.rsp_valid_o, 1'b0);
        check("arst_ready", bus.req_ready_o, 1'b0);
        check("arst_paddr", bus.paddr_o, '0);
        apb_q.delete();
        rsp_q.delete();
        hang = 0;
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("flushed_psel", bus.psel_o, 1'b0);
            check("flushed_ready", bus.req_ready_o, 1'b1);
        end

`ifdef APB_MASTER_TIMEOUT_EN
        // Stuck slave: abort after 32 ACCESS cycles, aborted write leaves memory unchanged.
        stuck = 1;
        send(1'b1, 10'h7, 32'h0BAD_0007, 1'b1);
        send(1'b0, 10'h7, 32'h0, 1'b0);
        wait_idle();
        wait_idle();
        check("timeout_len", last_acc_run, 32);
`endif

        // Randomised traffic over a small address window so reads hit earlier writes.
        fixed_wait = -1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 1'b0);
        end
        wait_idle();
        check("final_rsp_q_empty", rsp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
